// File: rtl/nibble_packer.sv
// Packs eight 4-bit nibbles MSB-first into 32-bit words and buffers them in a
// small FIFO with a valid/ready output. Define NIBBLE_PACKER_PARITY_EN to add WORD_PAR.
module nibble_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic [3:0]       NIBBLE_IN,
  input  logic             NIBBLE_VALID,
  input  logic             FLUSH,
  output logic [31:0]      WORD_OUT,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             FIFO_FULL,
`ifdef NIBBLE_PACKER_PARITY_EN
  output logic [CNT_W-1:0] DROP_CNT,
  output logic             WORD_PAR
`else
  output logic [CNT_W-1:0] DROP_CNT
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int ENT_W = 33;
`else
  localparam int ENT_W = 32;
`endif

  // Output handshake: a word transfers on any rising edge where
  // WORD_VALID && WORD_READY; WORD_OUT holds steady until then.

  logic [2:0]       r_idx;
  logic [31:0]      r_asm;
  logic [31:0]      w_asm_ins;
  logic [4:0]       w_shamt;
  logic             w_push;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_count;
  logic [OCC_W-1:0] w_count_nxt;
  logic             r_valid;
  logic             r_full;
  logic [CNT_W-1:0] r_drop;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;

  // Unfilled low nibbles are already zero, so OR-ing in place also pads flushes.
  always_comb begin
    w_shamt   = 5'd28 - {r_idx, 2'b00};
    w_asm_ins = r_asm;
    if (NIBBLE_VALID) begin
      w_asm_ins = r_asm | ({28'd0, NIBBLE_IN} << w_shamt);
    end
  end

  assign w_push = (NIBBLE_VALID && (r_idx == 3'd7)) ||
                  (FLUSH && ((r_idx != 3'd0) || NIBBLE_VALID));

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_idx <= 3'd0;
      r_asm <= 32'd0;
    end else if (w_push) begin
      r_idx <= 3'd0;
      r_asm <= 32'd0;
    end else if (NIBBLE_VALID) begin
      r_idx <= r_idx + 3'd1;
      r_asm <= w_asm_ins;
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign w_entry = {^w_asm_ins, w_asm_ins};
`else
  assign w_entry = w_asm_ins;
`endif

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_pop  = r_valid && WORD_READY;
  assign w_wr   = w_push && (!r_full || w_pop);
  assign w_drop = w_push && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + OCC_W'(1);
      2'b01:   w_count_nxt = r_count - OCC_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
      r_drop <= r_drop + CNT_W'(1);
    end
  end

  // Storage is not reset; gating with valid keeps the outputs at zero when empty.
  assign w_head     = r_mem[r_rptr];
  assign WORD_OUT   = r_valid ? w_head[31:0] : 32'd0;
  assign WORD_VALID = r_valid;
  assign FIFO_FULL  = r_full;
  assign DROP_CNT   = r_drop;
`ifdef NIBBLE_PACKER_PARITY_EN
  assign WORD_PAR   = r_valid ? w_head[32] : 1'b0;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: vector table, directed FIFO/reset
// sequences and randomized traffic against a queue-based reference model.
module tb_nibble_packer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RESET_L;
  logic [3:0]       NIBBLE_IN;
  logic             NIBBLE_VALID;
  logic             FLUSH;
  logic [31:0]      WORD_OUT;
  logic             WORD_VALID;
  logic             WORD_READY;
  logic             FIFO_FULL;
  logic [CNT_W-1:0] DROP_CNT;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic             WORD_PAR;
`endif

  nibble_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RESET_L      (RESET_L),
    .NIBBLE_IN    (NIBBLE_IN),
    .NIBBLE_VALID (NIBBLE_VALID),
    .FLUSH        (FLUSH),
    .WORD_OUT     (WORD_OUT),
    .WORD_VALID   (WORD_VALID),
    .WORD_READY   (WORD_READY),
    .FIFO_FULL    (FIFO_FULL),
`ifdef NIBBLE_PACKER_PARITY_EN
    .WORD_PAR     (WORD_PAR),
`endif
    .DROP_CNT     (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  cur_nibs[$];
  int          mdl_drop;

  typedef struct {
    logic        v;
    logic [3:0]  n;
    logic        f;
    logic        r;
    logic        ev;
    logic [31:0] ew;
  } vec_t;
  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    cur_nibs.delete();
    mdl_drop = 0;
  endtask

  task automatic mdl_check();
    check("mdl_valid", 32'(WORD_VALID), 32'(exp_q.size() > 0));
    check("mdl_full", 32'(FIFO_FULL), 32'(exp_q.size() == DEPTH));
    check("mdl_drop", 32'(DROP_CNT), 32'(mdl_drop));
    if (exp_q.size() > 0) begin
      check("mdl_word", WORD_OUT, exp_q[0]);
`ifdef NIBBLE_PACKER_PARITY_EN
      check("mdl_par", 32'(WORD_PAR), 32'(^exp_q[0]));
`endif
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic v, input logic [3:0] n, input logic f, input logic r);
    bit          pop;
    bit          push;
    logic [31:0] w;
    NIBBLE_VALID = v;
    NIBBLE_IN    = n;
    FLUSH        = f;
    WORD_READY   = r;
    pop  = (exp_q.size() > 0) && r;
    push = 0;
    w    = 32'd0;
    if (v) cur_nibs.push_back(n);
    if ((v && cur_nibs.size() == 8) || (f && cur_nibs.size() > 0)) begin
      foreach (cur_nibs[i]) w = w | (32'(cur_nibs[i]) << (28 - 4 * i));
      push = 1;
      cur_nibs.delete();
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else if (mdl_drop < (1 << CNT_W) - 1) mdl_drop++;
    end
    @(posedge CLK);
    #1;
    mdl_check();
  endtask

  task automatic push_word(input logic [31:0] w, input logic r_body, input logic r_last);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w[31 - 4 * i -: 4], 1'b0, (i == 7) ? r_last : r_body);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic [3:0] n, input logic f,
                         input logic r, input logic ev, input logic [31:0] ew);
    tbl[i].v  = v;
    tbl[i].n  = n;
    tbl[i].f  = f;
    tbl[i].r  = r;
    tbl[i].ev = ev;
    tbl[i].ew = ew;
  endtask

  initial begin
    RESET_L      = 1'b0;
    NIBBLE_IN    = 4'd0;
    NIBBLE_VALID = 1'b0;
    FLUSH        = 1'b0;
    WORD_READY   = 1'b0;
    mdl_reset();

    for (int k = 0; k < 8; k++) set_vec(k, 1'b1, 4'(k + 1), 1'b0, 1'b1, k == 7, 32'h12345678);
    set_vec(8, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    set_vec(9, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 32'h0);
    set_vec(10, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 32'h0);
    set_vec(11, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 32'h0);
    set_vec(12, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 32'hABC00000);
    for (int k = 13; k < 21; k++) set_vec(k, 1'b1, 4'hF, 1'b0, 1'b1, k == 20, 32'hFFFFFFFF);
    set_vec(21, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0);

    #12;
    check("rst_valid", 32'(WORD_VALID), 32'd0);
    check("rst_word", WORD_OUT, 32'd0);
    check("rst_full", 32'(FIFO_FULL), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'd0);
    RESET_L = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].n, tbl[i].f, tbl[i].r);
      check("tbl_valid", 32'(WORD_VALID), 32'(tbl[i].ev));
      if (tbl[i].ev) check("tbl_word", WORD_OUT, tbl[i].ew);
    end

    // Fill with the consumer stalled, overflow once, then drain in order.
    for (int k = 1; k <= 4; k++) push_word(32'(k), 1'b0, 1'b0);
    check("fill_full", 32'(FIFO_FULL), 32'd1);
    push_word(32'd5, 1'b0, 1'b0);
    check("ovf_drop", 32'(DROP_CNT), 32'd1);
    check("ovf_full", 32'(FIFO_FULL), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_word", WORD_OUT, 32'(k));
      step(1'b0, 4'h0, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(WORD_VALID), 32'd0);

    // Completion on a full FIFO while the consumer pops: no drop.
    for (int k = 10; k <= 13; k++) push_word(32'(k), 1'b0, 1'b0);
    push_word(32'd14, 1'b0, 1'b1);
    check("fullpop_full", 32'(FIFO_FULL), 32'd1);
    check("fullpop_drop", 32'(DROP_CNT), 32'd1);
    check("fullpop_head", WORD_OUT, 32'd11);
    for (int k = 11; k <= 14; k++) begin
      check("fullpop_drain", WORD_OUT, 32'(k));
      step(1'b0, 4'h0, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-cycle with a partial word and two buffered words.
    push_word(32'hAAAA0001, 1'b0, 1'b0);
    push_word(32'hAAAA0002, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'h1, 1'b0, 1'b0);
    NIBBLE_VALID = 1'b0;
    #2 RESET_L = 1'b0;
    #1;
    check("arst_valid", 32'(WORD_VALID), 32'd0);
    check("arst_word", WORD_OUT, 32'd0);
    check("arst_full", 32'(FIFO_FULL), 32'd0);
    check("arst_drop", 32'(DROP_CNT), 32'd0);
    mdl_reset();
    #1 RESET_L = 1'b1;
    push_word(32'h87654321, 1'b1, 1'b1);
    check("post_rst_valid", 32'(WORD_VALID), 32'd1);
    check("post_rst_word", WORD_OUT, 32'h87654321);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("post_rst_pop", 32'(WORD_VALID), 32'd0);

`ifdef NIBBLE_PACKER_PARITY_EN
    push_word(32'h00000007, 1'b1, 1'b1);
    check("par_odd", 32'(WORD_PAR), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    push_word(32'h00000003, 1'b1, 1'b1);
    check("par_even", 32'(WORD_PAR), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
`endif

    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) < ((c < 400) ? 1 : 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
